// File: rtl/pipe_reg_pkg.sv
// pipe_reg_pkg
// Shared definitions for the elastic register pipeline (pipe_reg_chain).
//   clog2_p1(depth) : bit width needed to hold a count of 0..depth
//   STALL_CNT_W     : width of the optional output-stall counter
package pipe_reg_pkg;

  localparam int STALL_CNT_W = 16;

  function automatic int clog2_p1(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage
// One pipeline slot: a WIDTH-bit data register plus its valid bit.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load              capture d_data/d_valid on this edge
//   clr               clear the valid bit (wins over load), data untouched
//   d_data, d_valid   incoming word
//   q_data, q_valid   stored word
module pipe_stage #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clr,
  input  logic [WIDTH-1:0] d_data,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q_data,
  output logic             q_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_data  <= RST_VAL;
      q_valid <= 1'b0;
    end else if (clr) begin
      q_valid <= 1'b0;
    end else if (load) begin
      q_data  <= d_data;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain
// Parametrised elastic register pipeline: DEPTH stages of WIDTH-bit data,
// valid/ready handshake on both ends, synchronous flush, global freeze enable.
// Empty stages always accept from upstream, so bubbles collapse while the
// output is stalled.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   enable                         0 freezes all state and masks the handshake
//   flush                          clears every valid bit on the next edge
//   in_valid, in_ready, in_data    upstream handshake (stage 0)
//   out_valid, out_ready, out_data downstream handshake (stage DEPTH-1)
//   occupancy                      registered count of valid stages
//   stall_cnt                      saturating count of stalled output cycles,
//                                  present only with PIPE_REG_CHAIN_STALL_CNT_EN
module pipe_reg_chain
  import pipe_reg_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [clog2_p1(DEPTH)-1:0]   occupancy
`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0]       stall_cnt
`endif
);

  localparam int OCC_W = clog2_p1(DEPTH);

  logic                 run;
  logic [DEPTH:0]       adv;
  logic [DEPTH-1:0]     valid_q;
  logic [DEPTH-1:0]     src_valid;
  logic [DEPTH-1:0]     valid_nxt;
  logic [WIDTH-1:0]     data_q   [DEPTH];
  logic [WIDTH-1:0]     src_data [DEPTH];
  logic [OCC_W-1:0]     occ_nxt;
  logic [OCC_W-1:0]     occ_q;

  assign run = enable & ~flush;

  // Ready ripples combinationally from the output back to stage 0: a stage
  // moves if it is empty or the stage below it moves this cycle.
  always_comb begin
    adv        = '0;
    adv[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv[i] = run & (~valid_q[i] | adv[i+1]);
    end
  end

  always_comb begin
    src_data[0]  = in_data;
    src_valid[0] = in_valid;
    for (int i = 1; i < DEPTH; i++) begin
      src_data[i]  = data_q[i-1];
      src_valid[i] = valid_q[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    pipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .load    (adv[g]),
      .clr     (flush),
      .d_data  (src_data[g]),
      .d_valid (src_valid[g]),
      .q_data  (data_q[g]),
      .q_valid (valid_q[g])
    );
  end

  // Occupancy is the popcount of the valid bits as they will be after this
  // edge, so it updates on the same edge as the stages themselves.
  always_comb begin
    valid_nxt = '0;
    occ_nxt   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush)       valid_nxt[i] = 1'b0;
      else if (adv[i]) valid_nxt[i] = src_valid[i];
      else             valid_nxt[i] = valid_q[i];
      occ_nxt = occ_nxt + OCC_W'(valid_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_nxt;
  end

  // rst gates in_ready directly so upstream never sees ready during reset.
  assign in_ready  = adv[0] & ~rst;
  assign out_valid = valid_q[DEPTH-1] & run;
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occ_q;

`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (valid_q[DEPTH-1] & run & ~out_ready & (stall_q != '1)) begin
      stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
